// File: rtl/gpc_pkg.sv
// Shared constants and helpers for the (3,1,1;4) generalized parallel counter.
// Column heights from weight 1 up, output width, and a 3-bit population count.
package gpc_pkg;

    localparam int COL0_H = 1;
    localparam int COL1_H = 1;
    localparam int COL2_H = 3;
    localparam int OUT_W  = 4;

    // Two-bit count of ones: bit 0 is the parity, bit 1 the majority.
    function automatic logic [1:0] popcount3(input logic [2:0] b);
        return {1'b0, b[0]} + {1'b0, b[1]} + {1'b0, b[2]};
    endfunction

endpackage

// File: rtl/gpc311_4_core.sv
// Combinational (3,1,1;4) GPC core: columns are summed independently.
// Ports: src0 (w1), src1 (w2), src2[2:0] (w4) in; dst[3:0] binary sum out.
module gpc311_4_core
    import gpc_pkg::*;
(
    input  logic [COL0_H-1:0] src0,
    input  logic [COL1_H-1:0] src1,
    input  logic [COL2_H-1:0] src2,
    output logic [OUT_W-1:0]  dst
);

    // The weight-4 column never carries into lower bits, so its
    // popcount lands directly in dst[3:2].
    assign dst = {popcount3(src2), src1[0], src0[0]};

endmodule

// File: rtl/gpc_311_4.sv
// Registered (3,1,1;4) GPC with optional input and output pipeline stages.
// Ports: clk, rst (sync, active-high), src0/src1/src2 in, dst[3:0] out.
module gpc_311_4
    import gpc_pkg::*;
#(
    parameter int IN_REG  = 0,
    parameter int OUT_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COL0_H-1:0] src0,
    input  logic [COL1_H-1:0] src1,
    input  logic [COL2_H-1:0] src2,
    output logic [OUT_W-1:0]  dst
);

    logic [COL0_H-1:0] c_src0;
    logic [COL1_H-1:0] c_src1;
    logic [COL2_H-1:0] c_src2;
    logic [OUT_W-1:0]  sum;

    generate
        if (IN_REG != 0) begin : g_in_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    c_src0 <= '0;
                    c_src1 <= '0;
                    c_src2 <= '0;
                end else begin
                    c_src0 <= src0;
                    c_src1 <= src1;
                    c_src2 <= src2;
                end
            end
        end else begin : g_in_wire
            assign c_src0 = src0;
            assign c_src1 = src1;
            assign c_src2 = src2;
        end
    endgenerate

    gpc311_4_core u_core (
        .src0 (c_src0),
        .src1 (c_src1),
        .src2 (c_src2),
        .dst  (sum)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk) begin
                if (rst) dst <= '0;
                else     dst <= sum;
            end
        end else begin : g_out_wire
            assign dst = sum;
        end
    endgenerate

endmodule

// File: tb/tb_gpc_311_4.sv
// Scoreboard bench for gpc_311_4 in three pipeline configurations.
// Latency 1 (defaults), latency 2 (both regs) and latency 0 (combinational).
module tb_gpc_311_4;

    typedef struct {
        int         issue;
        logic [4:0] v;
    } item_t;

    logic       clk;
    logic       rst;
    logic [0:0] src0;
    logic [0:0] src1;
    logic [2:0] src2;
    logic [3:0] dst_d;
    logic [3:0] dst_2;
    logic [3:0] dst_0;

    int    cyc;
    int    n_checks;
    int    n_fail;
    bit    rst_hist [0:8191];
    item_t q_d[$];
    item_t q_2[$];
    item_t q_0[$];

    gpc_311_4 u_def (
        .clk(clk), .rst(rst), .src0(src0), .src1(src1), .src2(src2),
        .dst(dst_d)
    );

    gpc_311_4 #(.IN_REG(1), .OUT_REG(1)) u_lat2 (
        .clk(clk), .rst(rst), .src0(src0), .src1(src1), .src2(src2),
        .dst(dst_2)
    );

    gpc_311_4 #(.IN_REG(0), .OUT_REG(0)) u_lat0 (
        .clk(clk), .rst(rst), .src0(src0), .src1(src1), .src2(src2),
        .dst(dst_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain weighted sum of the input bits.
    function automatic int ref_sum(input logic [4:0] v);
        int s;
        s = int'(v[0]) + 2 * int'(v[1]);
        s = s + 4 * (int'(v[2]) + int'(v[3]) + int'(v[4]));
        return s;
    endfunction

    // A vector is lost if reset was sampled at any edge while it was in flight.
    function automatic int expect_val(input item_t it, input int lat);
        for (int k = it.issue; k < it.issue + lat; k++)
            if (rst_hist[k]) return 0;
        return ref_sum(it.v);
    endfunction

    function automatic void check(input string nm, input item_t it,
                                  input int lat, input logic [3:0] act);
        int e;
        e = expect_val(it, lat);
        n_checks++;
        if (int'(act) != e) begin
            n_fail++;
            $display("FAIL %s issue=%0d vec=%h dst=%0d expected=%0d",
                     nm, it.issue, it.v, act, e);
        end
    endfunction

    // Monitor: compare every vector whose latency has elapsed.
    always @(negedge clk) begin
        while (q_d.size() > 0 && q_d[0].issue + 1 == cyc)
            check("lat1", q_d.pop_front(), 1, dst_d);
        while (q_2.size() > 0 && q_2[0].issue + 2 == cyc)
            check("lat2", q_2.pop_front(), 2, dst_2);
        while (q_0.size() > 0 && q_0[0].issue == cyc)
            check("lat0", q_0.pop_front(), 0, dst_0);
    end

    task automatic drive(input logic [4:0] v, input logic r);
        item_t it;
        @(posedge clk);
        #1;
        rst = r;
        {src2, src1, src0} = v;
        rst_hist[cyc] = r;
        it.issue = cyc;
        it.v     = v;
        q_d.push_back(it);
        q_2.push_back(it);
        q_0.push_back(it);
    endtask

    initial begin
        logic [4:0] perm [0:5];
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        {src2, src1, src0} = 5'h1f;
        perm[0] = 5'b00100;
        perm[1] = 5'b01000;
        perm[2] = 5'b10000;
        perm[3] = 5'b01100;
        perm[4] = 5'b10100;
        perm[5] = 5'b11000;

        // Reset state with all-ones held on the inputs.
        drive(5'h1f, 1'b1);
        drive(5'h1f, 1'b1);

        // Exhaustive sweep.
        for (int i = 0; i < 32; i++) drive(5'(i), 1'b0);

        // src2 permutations.
        for (int i = 0; i < 6; i++) drive(perm[i], 1'b0);

        // Mid-stream reset with 5'h1f held, then release.
        drive(5'h1f, 1'b0);
        drive(5'h1f, 1'b1);
        drive(5'h1f, 1'b0);
        drive(5'h1f, 1'b0);
        drive(5'h0b, 1'b0);
        drive(5'h0b, 1'b1);
        drive(5'h0b, 1'b0);
        drive(5'h0b, 1'b0);

        // Back-to-back alternating stream.
        for (int i = 0; i < 16; i++) drive((i % 2 == 0) ? 5'h00 : 5'h1f, 1'b0);

        // Random vectors with occasional reset.
        for (int i = 0; i < 300; i++)
            drive(5'($urandom_range(0, 31)), ($urandom_range(0, 19) == 0));

        drive(5'h00, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);

        n_checks++;
        if (q_d.size() + q_2.size() + q_0.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0",
                     q_d.size() + q_2.size() + q_0.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
